// File: rtl/cnn_stream_pkg.sv
// cnn_stream_pkg
// Shared definitions for the CNN stream master slice:
//   - state_e    : master FSM state encoding
//   - DATA_W_DEF : default stream word width
//   - cnt_w()    : width of a counter that must hold the value n
package cnn_stream_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Bits needed to represent 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cnn_stream_if.sv
// cnn_stream_if
// Bundles every handshake/status signal of the CNN stream master.
//   host side : start, src_valid/src_ready/src_data,
//               res_valid/res_ready/res_data, busy/done/err
//   core side : valid_in/data_in (to core), valid_out/data_out (from core)
// Modports: master = view of cnn_stream_master, slave = view of the
// host/core environment driving it.
interface cnn_stream_if
  import cnn_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, src_valid, src_data, valid_out, data_out, res_ready,
    output src_ready, valid_in, data_in, res_valid, res_data, busy, done, err
  );

  modport slave (
    output start, src_valid, src_data, valid_out, data_out, res_ready,
    input  src_ready, valid_in, data_in, res_valid, res_data, busy, done, err
  );

endinterface

// File: rtl/cnn_stream_fifo.sv
// cnn_stream_fifo
// Synchronous single-clock FIFO holding result words for the host.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : synchronous empty of all contents (wins over push/pop)
//   push, wdata   : write request and data; ignored when full unless a pop
//                   happens in the same cycle
//   pop           : read request; ignored when empty
//   rdata         : current head word
//   full, empty   : occupancy flags
module cnn_stream_fifo
  import cnn_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int LP_PTR_W = cnt_w(DEPTH - 1);
  localparam int LP_CNT_W = cnt_w(DEPTH);
  // Storage is rounded up to a power of two so any pointer value indexes a
  // real entry; pointers still wrap at DEPTH.
  localparam int LP_MEM_N = 1 << LP_PTR_W;
  localparam logic [LP_PTR_W-1:0] LP_PTR_LAST = LP_PTR_W'(DEPTH - 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_FULL = LP_CNT_W'(DEPTH);

  logic [WIDTH-1:0]    r_mem [LP_MEM_N];
  logic [LP_PTR_W-1:0] r_wr_ptr;
  logic [LP_PTR_W-1:0] r_rd_ptr;
  logic [LP_CNT_W-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  function automatic logic [LP_PTR_W-1:0] ptr_inc(input logic [LP_PTR_W-1:0] p);
    return (p == LP_PTR_LAST) ? {LP_PTR_W{1'b0}} : p + 1'b1;
  endfunction

  assign full  = (r_count == LP_CNT_FULL);
  assign empty = (r_count == {LP_CNT_W{1'b0}});
  assign rdata = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_push = push && (!full || w_pop);

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= {LP_PTR_W{1'b0}};
      r_rd_ptr <= {LP_PTR_W{1'b0}};
      r_count  <= {LP_CNT_W{1'b0}};
      for (int i = 0; i < LP_MEM_N; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cnn_stream_master.sv
// cnn_stream_master
// Feeds one frame of FRAME_WORDS host words to a CNN core, collects
// RESULT_WORDS result words into a FIFO and hands them to the host.
// Ports:
//   clk   : sole clock, posedge
//   rst_n : synchronous ACTIVE-HIGH reset (historic name kept)
//   bus   : cnn_stream_if.master -- start, src_*, valid_in/data_in,
//           valid_out/data_out, res_*, busy/done/err
// Optional feature: define CNN_STREAM_TIMEOUT_EN to build a WAIT-state
// watchdog that forces ERR after TIMEOUT_CYC cycles with no result word.
// Without it WAIT waits indefinitely.
// done is high in the first IDLE cycle after DRAIN; err is high during the
// single ERR cycle.
module cnn_stream_master
  import cnn_stream_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FRAME_WORDS  = 784,
  parameter int RESULT_WORDS = 10,
  parameter int TIMEOUT_CYC  = 65535,
  parameter int FIFO_DEPTH   = RESULT_WORDS
) (
  input logic          clk,
  input logic          rst_n,
  cnn_stream_if.master bus
);

  localparam int LP_WORD_W = cnt_w(FRAME_WORDS);
  localparam int LP_RES_W  = cnt_w(RESULT_WORDS);
  localparam logic [LP_WORD_W-1:0] LP_LAST_WORD = LP_WORD_W'(FRAME_WORDS - 1);
  localparam logic [LP_RES_W-1:0]  LP_RES_ALL   = LP_RES_W'(RESULT_WORDS);

  state_e               r_state;
  logic [LP_WORD_W-1:0] r_word_cnt;
  logic [LP_RES_W-1:0]  r_res_cnt;
  logic                 r_overflow;
  logic                 r_src_ready;
  logic                 r_valid_in;
  logic [DATA_W-1:0]    r_data_in;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_fifo_flush;
  logic w_pop;
  logic w_capture_win;
  logic w_push;
  logic w_overflow;
  logic w_timeout;

  // Results are accepted only while the frame is live and still short of
  // RESULT_WORDS; anything beyond is silently ignored.
  assign w_capture_win = ((r_state == ST_SEND) || (r_state == ST_WAIT)) &&
                         (r_res_cnt != LP_RES_ALL) && !r_overflow;
  assign w_pop         = bus.res_ready && !w_fifo_empty;
  assign w_push        = bus.valid_out && w_capture_win && (!w_fifo_full || w_pop);
  assign w_overflow    = bus.valid_out && w_capture_win && w_fifo_full && !w_pop;
  assign w_fifo_flush  = (r_state == ST_ERR);

`ifdef CNN_STREAM_TIMEOUT_EN
  localparam int LP_TMR_W = cnt_w(TIMEOUT_CYC);
  localparam logic [LP_TMR_W-1:0] LP_TMR_LAST = LP_TMR_W'(TIMEOUT_CYC - 1);

  logic [LP_TMR_W-1:0] r_timer;

  // Counts silent WAIT cycles; any result word or leaving WAIT restarts it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_timer <= {LP_TMR_W{1'b0}};
    end else if ((r_state == ST_WAIT) && !bus.valid_out) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= {LP_TMR_W{1'b0}};
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !bus.valid_out && (r_timer == LP_TMR_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Master FSM with all host/core outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= {LP_WORD_W{1'b0}};
      r_res_cnt   <= {LP_RES_W{1'b0}};
      r_overflow  <= 1'b0;
      r_src_ready <= 1'b0;
      r_valid_in  <= 1'b0;
      r_data_in   <= {DATA_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid_in <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_push) begin
        r_res_cnt <= r_res_cnt + 1'b1;
      end
      if (w_overflow) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_SEND;
            r_word_cnt  <= {LP_WORD_W{1'b0}};
            r_res_cnt   <= {LP_RES_W{1'b0}};
            r_overflow  <= 1'b0;
            r_src_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_overflow) begin
            r_state     <= ST_ERR;
            r_src_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b1;
          end else if (bus.src_valid) begin
            r_valid_in <= 1'b1;
            r_data_in  <= bus.src_data;
            if (r_word_cnt == LP_LAST_WORD) begin
              r_state     <= ST_WAIT;
              r_src_ready <= 1'b0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (w_overflow || w_timeout) begin
            r_state <= ST_ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (r_res_cnt == LP_RES_ALL) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_fifo_empty) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_src_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  cnn_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .flush (w_fifo_flush),
    .push  (w_push),
    .wdata (bus.data_out),
    .pop   (w_pop),
    .rdata (bus.res_data),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign bus.src_ready = r_src_ready;
  assign bus.valid_in  = r_valid_in;
  assign bus.data_in   = r_data_in;
  assign bus.res_valid = !w_fifo_empty;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_cnn_stream_master.sv
// tb_cnn_stream_master
// Directed bench for cnn_stream_master. Two instances share the same input
// stimulus: dut_a (FRAME_WORDS=4, RESULT_WORDS=2, TIMEOUT_CYC=16) and
// dut_b (same, with the result FIFO reduced to one entry).
module tb_cnn_stream_master;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          res_ready;

  int checks   = 0;
  int failures = 0;
  int err_a    = 0;
  int done_a   = 0;
  int err_b    = 0;

  always #5 clk = ~clk;

  cnn_stream_if #(.DATA_W(DW)) ifa ();
  cnn_stream_if #(.DATA_W(DW)) ifb ();

  assign ifa.start     = start;
  assign ifa.src_valid = src_valid;
  assign ifa.src_data  = src_data;
  assign ifa.valid_out = valid_out;
  assign ifa.data_out  = data_out;
  assign ifa.res_ready = res_ready;
  assign ifb.start     = start;
  assign ifb.src_valid = src_valid;
  assign ifb.src_data  = src_data;
  assign ifb.valid_out = valid_out;
  assign ifb.data_out  = data_out;
  assign ifb.res_ready = res_ready;

  cnn_stream_master #(
    .DATA_W(DW), .FRAME_WORDS(4), .RESULT_WORDS(2), .TIMEOUT_CYC(16), .FIFO_DEPTH(2)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  cnn_stream_master #(
    .DATA_W(DW), .FRAME_WORDS(4), .RESULT_WORDS(2), .TIMEOUT_CYC(16), .FIFO_DEPTH(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (ifa.err === 1'b1)  err_a  <= err_a + 1;
    if (ifa.done === 1'b1) done_a <= done_a + 1;
    if (ifb.err === 1'b1)  err_b  <= err_b + 1;
  end

  typedef struct {
    logic          rst;
    logic          st;
    logic          sv;
    logic [DW-1:0] sd;
    logic          vo;
    logic [DW-1:0] dout;
    logic          rr;
    logic          e_sr;
    logic          e_vi;
    logic [DW-1:0] e_di;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    src_valid = 1'b0;
    src_data  = 32'h0;
    valid_out = 1'b0;
    data_out  = 32'h0;
    res_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0;
    cyc();
  endtask

  // Start a frame and stream four consecutive words from base.
  task automatic send_frame(input logic [31:0] base);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1;
      src_data  = base + 32'(i);
      cyc();
      chk("frame_valid_in", {31'h0, ifa.valid_in}, 32'h1);
      chk("frame_data_in", ifa.data_in, base + 32'(i));
    end
    src_valid = 1'b0;
    src_data  = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int d0;
    int early;

    //            rst   st    sv    sd     vo    dout   rr    sr    vi    di     rv    rd     busy  done  err
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB, 1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'hB, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    rst_n = 1'b1;

    // Table: reset, full frame, two results, drain and done.
    for (int i = 0; i < 13; i++) begin
      rst_n     = vecs[i].rst;
      start     = vecs[i].st;
      src_valid = vecs[i].sv;
      src_data  = vecs[i].sd;
      valid_out = vecs[i].vo;
      data_out  = vecs[i].dout;
      res_ready = vecs[i].rr;
      cyc();
      chk($sformatf("v%0d_src_ready", i), {31'h0, ifa.src_ready}, {31'h0, vecs[i].e_sr});
      chk($sformatf("v%0d_valid_in", i),  {31'h0, ifa.valid_in},  {31'h0, vecs[i].e_vi});
      chk($sformatf("v%0d_data_in", i),   ifa.data_in,            vecs[i].e_di);
      chk($sformatf("v%0d_res_valid", i), {31'h0, ifa.res_valid}, {31'h0, vecs[i].e_rv});
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_res_data", i), ifa.res_data, vecs[i].e_rd);
      end
      chk($sformatf("v%0d_busy", i), {31'h0, ifa.busy}, {31'h0, vecs[i].e_busy});
      chk($sformatf("v%0d_done", i), {31'h0, ifa.done}, {31'h0, vecs[i].e_done});
      chk($sformatf("v%0d_err", i),  {31'h0, ifa.err},  {31'h0, vecs[i].e_err});
    end
    idle_inputs();

    // Three results with the host stalled: third is ignored, no error.
    apply_reset();
    e0 = err_a;
    d0 = done_a;
    send_frame(32'h100);
    valid_out = 1'b1;
    data_out  = 32'h11;
    cyc();
    data_out  = 32'h22;
    cyc();
    data_out  = 32'h33;
    cyc();
    valid_out = 1'b0;
    chk("extra_res_valid", {31'h0, ifa.res_valid}, 32'h1);
    chk("extra_res_head", ifa.res_data, 32'h11);
    chk("extra_busy", {31'h0, ifa.busy}, 32'h1);
    cyc();
    cyc();
    chk("extra_still_drain", {31'h0, ifa.busy}, 32'h1);
    res_ready = 1'b1;
    cyc();
    chk("extra_second_word", ifa.res_data, 32'h22);
    cyc();
    chk("extra_empty", {31'h0, ifa.res_valid}, 32'h0);
    res_ready = 1'b0;
    cyc();
    chk("extra_done", {31'h0, ifa.done}, 32'h1);
    chk("extra_busy_fall", {31'h0, ifa.busy}, 32'h0);
    cyc();
    chk("extra_no_err", 32'(err_a - e0), 32'h0);
    chk("extra_one_done", 32'(done_a - d0), 32'h1);

    // One-entry FIFO on dut_b: second result overflows.
    apply_reset();
    e0 = err_b;
    send_frame(32'h200);
    valid_out = 1'b1;
    data_out  = 32'h1;
    cyc();
    chk("ovf_first_held", {31'h0, ifb.res_valid}, 32'h1);
    data_out  = 32'h2;
    cyc();
    valid_out = 1'b0;
    chk("ovf_err_pulse", {31'h0, ifb.err}, 32'h1);
    chk("ovf_busy", {31'h0, ifb.busy}, 32'h0);
    chk("ovf_head_kept", ifb.res_data, 32'h1);
    chk("ovf_deep_fifo_ok", {31'h0, ifa.err}, 32'h0);
    cyc();
    chk("ovf_err_single", {31'h0, ifb.err}, 32'h0);
    chk("ovf_flushed", {31'h0, ifb.res_valid}, 32'h0);
    chk("ovf_src_ready", {31'h0, ifb.src_ready}, 32'h0);
    cyc();
    chk("ovf_err_count", 32'(err_b - e0), 32'h1);

    // Silence after the frame.
    apply_reset();
    send_frame(32'h300);
`ifdef CNN_STREAM_TIMEOUT_EN
    early = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i < 16) begin
        if (ifa.err !== 1'b0) early++;
      end else begin
        chk("tmo_err_at_16", {31'h0, ifa.err}, 32'h1);
      end
    end
    chk("tmo_no_early_err", 32'(early), 32'h0);
    cyc();
    chk("tmo_err_single", {31'h0, ifa.err}, 32'h0);
    chk("tmo_idle", {31'h0, ifa.busy}, 32'h0);
`else
    early = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (ifa.err !== 1'b0) early++;
    end
    chk("wait_forever_busy", {31'h0, ifa.busy}, 32'h1);
    chk("wait_forever_no_err", 32'(early), 32'h0);
`endif

    // Reset during the third word, then a clean frame.
    apply_reset();
    e0 = err_a;
    d0 = done_a;
    start = 1'b1;
    cyc();
    start     = 1'b0;
    src_valid = 1'b1;
    src_data  = 32'h1;
    cyc();
    src_data  = 32'h2;
    cyc();
    src_data  = 32'h3;
    rst_n     = 1'b1;
    cyc();
    rst_n     = 1'b0;
    src_valid = 1'b0;
    chk("rst_src_ready", {31'h0, ifa.src_ready}, 32'h0);
    chk("rst_valid_in", {31'h0, ifa.valid_in}, 32'h0);
    chk("rst_data_in", ifa.data_in, 32'h0);
    chk("rst_res_valid", {31'h0, ifa.res_valid}, 32'h0);
    chk("rst_busy", {31'h0, ifa.busy}, 32'h0);
    chk("rst_done", {31'h0, ifa.done}, 32'h0);
    chk("rst_err", {31'h0, ifa.err}, 32'h0);
    cyc();
    chk("rst_silent_err", 32'(err_a - e0), 32'h0);
    chk("rst_silent_done", 32'(done_a - d0), 32'h0);
    send_frame(32'h5);
    chk("refr_src_ready_low", {31'h0, ifa.src_ready}, 32'h0);
    res_ready = 1'b1;
    valid_out = 1'b1;
    data_out  = 32'h21;
    cyc();
    chk("refr_res_first", ifa.res_data, 32'h21);
    data_out  = 32'h22;
    cyc();
    valid_out = 1'b0;
    chk("refr_res_second", ifa.res_data, 32'h22);
    cyc();
    cyc();
    chk("refr_done", {31'h0, ifa.done}, 32'h1);
    chk("refr_busy_fall", {31'h0, ifa.busy}, 32'h0);
    idle_inputs();
    cyc();
    chk("refr_no_err", 32'(err_a - e0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
